// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared MEM-stage FSM encodings and load error constant
package mem_stage_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mem_state_e;
  localparam logic [15:0] ERR_DATA = 16'hFFFF;
endpackage

// File: rtl/dff.sv
// dff: team register cell with write enable and asynchronous active-high reset to zero
//   clk, rst: clock and async reset; wen_i: load enable; d_i/q_o: data in/out
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wen_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q_o <= '0;
    else if (wen_i) q_o <= d_i;
endmodule

// File: rtl/mem_fwd_mux.sv
// mem_fwd_mux: picks WB write-back data over EX/MEM store data on a register hazard
//   reg_write_i/dest_i/wb_data_i: WB stage write; src_i/store_data_i: store source; data_o: chosen data
module mem_fwd_mux (
  input  logic        reg_write_i,
  input  logic [3:0]  dest_i,
  input  logic [15:0] wb_data_i,
  input  logic [3:0]  src_i,
  input  logic [15:0] store_data_i,
  output logic [15:0] data_o
);
  assign data_o = (reg_write_i && dest_i == src_i && src_i != 4'd0) ? wb_data_i : store_data_i;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage driving a handshaked data memory with stall and timeout
//   inputs: EX/MEM access fields, WB forwarding fields, mem_rdata/mem_ack from memory
//   outputs: mem_req/mem_we/mem_addr/mem_wdata to memory, M_MemData load result,
//            mem_stall pipeline freeze, mem_err sticky timeout flag
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] M_ALUout,
  input  logic [15:0] M_StoreData,
  input  logic [3:0]  M_SrcReg,
  input  logic        M_MemRead,
  input  logic        M_MemWrite,
  input  logic        W_RegWrite,
  input  logic [3:0]  W_Destination,
  input  logic [15:0] W_WriteData,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [15:0] M_MemData,
  output logic        mem_stall,
  output logic        mem_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic          rst, latch, busy, timeout, rd_wen;
  logic [1:0]    state_q;
  mem_state_e    state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   fwd_data, rdata_d;
  assign rst     = ~rst_n;
  assign busy    = state_q == BUSY;
  assign latch   = state_q == IDLE && (M_MemRead || M_MemWrite);
  // cnt_q counts BUSY cycles already spent, so the TIMEOUT-th cycle sees TIMEOUT-1
  assign timeout = busy && !mem_ack && cnt_q == CW'(TIMEOUT - 1);
  // only loads touch the read register; stores leave the last load result visible
  assign rd_wen  = busy && !mem_we && (mem_ack || timeout);
  always_comb begin
    state_d = latch ? BUSY : (busy && !mem_ack && !timeout) ? BUSY : busy ? DONE : IDLE;
    cnt_d   = (busy && !mem_ack) ? cnt_q + CW'(1) : '0;
    rdata_d = mem_ack ? mem_rdata : ERR_DATA;
  end
  mem_fwd_mux u_fwd (
    .reg_write_i (W_RegWrite),
    .dest_i      (W_Destination),
    .wb_data_i   (W_WriteData),
    .src_i       (M_SrcReg),
    .store_data_i(M_StoreData),
    .data_o      (fwd_data)
  );
  dff #(.W(2))  u_state (.clk(clk), .rst(rst), .wen_i(1'b1),  .d_i(state_d),    .q_o(state_q));
  dff #(.W(CW)) u_cnt   (.clk(clk), .rst(rst), .wen_i(1'b1),  .d_i(cnt_d),      .q_o(cnt_q));
  dff #(.W(16)) u_addr  (.clk(clk), .rst(rst), .wen_i(latch), .d_i(M_ALUout),   .q_o(mem_addr));
  dff #(.W(16)) u_wdata (.clk(clk), .rst(rst), .wen_i(latch), .d_i(fwd_data),   .q_o(mem_wdata));
  dff #(.W(1))  u_we    (.clk(clk), .rst(rst), .wen_i(latch), .d_i(M_MemWrite), .q_o(mem_we));
  dff #(.W(16)) u_rdata (.clk(clk), .rst(rst), .wen_i(rd_wen), .d_i(rdata_d),   .q_o(M_MemData));
  dff #(.W(1))  u_err   (.clk(clk), .rst(rst), .wen_i(timeout), .d_i(1'b1),     .q_o(mem_err));
  assign mem_req   = busy;
  assign mem_stall = latch || busy;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table, directed corner sequences and random run against a transaction model
module tb_mem_stage;
  localparam int TO = 8;
  logic        clk = 1'b0, rst_n;
  logic [15:0] M_ALUout, M_StoreData, W_WriteData, mem_rdata;
  logic [3:0]  M_SrcReg, W_Destination;
  logic        M_MemRead, M_MemWrite, W_RegWrite, mem_ack;
  logic        mem_req, mem_we, mem_stall, mem_err;
  logic [15:0] mem_addr, mem_wdata, M_MemData;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .M_ALUout(M_ALUout), .M_StoreData(M_StoreData), .M_SrcReg(M_SrcReg),
    .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .W_RegWrite(W_RegWrite),
    .W_Destination(W_Destination), .W_WriteData(W_WriteData), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .M_MemData(M_MemData), .mem_stall(mem_stall), .mem_err(mem_err)
  );
  typedef struct {
    logic        rd;
    logic        rw;
    logic [3:0]  dest;
    logic [3:0]  src;
    logic [15:0] wd;
    logic [15:0] sd;
    logic [15:0] exp_wd;
  } fwd_vec_t;
  fwd_vec_t vecs[7];
  // transaction-level reference: how many BUSY cycles the open access has used, or -1
  int          m_busy;
  bit          m_done, m_we, m_err;
  logic [15:0] m_addr, m_wd, m_data;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in;
    M_MemRead = 0; M_MemWrite = 0; mem_ack = 0; W_RegWrite = 0;
  endtask
  task automatic do_reset;
    idle_in();
    rst_n = 0;
    #2;
    rst_n = 1;
    tick();
  endtask
  task automatic model_step;
    if (m_done) m_done = 0;
    else if (m_busy >= 0) begin
      m_busy++;
      if (mem_ack) begin
        if (!m_we) m_data = mem_rdata;
        m_busy = -1; m_done = 1;
      end else if (m_busy == TO) begin
        m_err = 1;
        if (!m_we) m_data = 16'hFFFF;
        m_busy = -1; m_done = 1;
      end
    end else if (M_MemRead || M_MemWrite) begin
      m_addr = M_ALUout;
      m_we   = M_MemWrite;
      m_wd   = (W_RegWrite && W_Destination == M_SrcReg && M_SrcReg != 0) ? W_WriteData : M_StoreData;
      m_busy = 0;
    end
  endtask
  initial begin
    int n, stall_cnt;
    int pat[6];
    pat = '{1, 1, 0, 1, 1, 0};
    vecs[0] = '{1'b0, 1'b1, 4'd3,  4'd3,  16'h1234, 16'hAAAA, 16'h1234};
    vecs[1] = '{1'b0, 1'b1, 4'd0,  4'd0,  16'h1234, 16'hAAAA, 16'hAAAA};
    vecs[2] = '{1'b0, 1'b0, 4'd5,  4'd5,  16'h5555, 16'h0BAD, 16'h0BAD};
    vecs[3] = '{1'b0, 1'b1, 4'd6,  4'd7,  16'h6666, 16'h0C0C, 16'h0C0C};
    vecs[4] = '{1'b0, 1'b1, 4'd15, 4'd15, 16'hFACE, 16'h0D0D, 16'hFACE};
    vecs[5] = '{1'b1, 1'b1, 4'd2,  4'd2,  16'h2222, 16'h0E0E, 16'h2222};
    vecs[6] = '{1'b1, 1'b0, 4'd9,  4'd9,  16'h9999, 16'h0F0F, 16'h0F0F};
    M_ALUout = 16'h0; M_StoreData = 16'h0; W_WriteData = 16'h0; mem_rdata = 16'h0;
    M_SrcReg = 4'd0; W_Destination = 4'd0;
    idle_in();
    rst_n = 0;
    #2;
    chk("rst_req", 16'(mem_req), 16'h0);
    chk("rst_we", 16'(mem_we), 16'h0);
    chk("rst_err", 16'(mem_err), 16'h0);
    chk("rst_addr", mem_addr, 16'h0);
    chk("rst_wdata", mem_wdata, 16'h0);
    chk("rst_data", M_MemData, 16'h0);
    rst_n = 1;
    tick();
    // forwarding table, each entry a store acked in its first BUSY cycle
    for (int i = 0; i < 7; i++) begin
      M_MemWrite = 1; M_MemRead = vecs[i].rd; M_ALUout = 16'h0040 + 16'(i);
      M_StoreData = vecs[i].sd; M_SrcReg = vecs[i].src; W_RegWrite = vecs[i].rw;
      W_Destination = vecs[i].dest; W_WriteData = vecs[i].wd; mem_ack = 0;
      #1;
      chk("vec_stall_idle", 16'(mem_stall), 16'h1);
      tick();
      W_WriteData = ~vecs[i].wd; M_StoreData = ~vecs[i].sd; M_ALUout = 16'hFFFF;
      #1;
      chk("vec_wdata", mem_wdata, vecs[i].exp_wd);
      chk("vec_we", 16'(mem_we), 16'h1);
      chk("vec_addr", mem_addr, 16'h0040 + 16'(i));
      chk("vec_req", 16'(mem_req), 16'h1);
      mem_ack = 1;
      tick();
      idle_in();
      #1;
      chk("vec_done_req", 16'(mem_req), 16'h0);
      chk("vec_done_stall", 16'(mem_stall), 16'h0);
      chk("vec_store_keeps_data", M_MemData, 16'h0);
      tick();
    end
    // load acked in third BUSY cycle
    do_reset();
    M_ALUout = 16'h0010; M_MemRead = 1; mem_rdata = 16'hBEEF; stall_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      mem_ack = (c == 3);
      #1;
      stall_cnt += int'(mem_stall);
      if (c == 4) begin
        chk("ld3_data", M_MemData, 16'hBEEF);
        chk("ld3_err", 16'(mem_err), 16'h0);
        M_MemRead = 0;
      end
      tick();
    end
    chk("ld3_stall_cycles", 16'(stall_cnt), 16'd4);
    mem_ack = 1; mem_rdata = 16'h7777;
    #1;
    chk("idle_ack_req", 16'(mem_req), 16'h0);
    tick();
    chk("idle_ack_stall", 16'(mem_stall), 16'h0);
    chk("idle_ack_data", M_MemData, 16'hBEEF);
    // forwarded store held stable over three BUSY cycles
    idle_in();
    M_MemWrite = 1; M_ALUout = 16'h0040; M_SrcReg = 4'd3; W_Destination = 4'd3;
    W_RegWrite = 1; W_WriteData = 16'h1234; M_StoreData = 16'hAAAA;
    #1;
    tick();
    for (int b = 0; b < 3; b++) begin
      W_WriteData = 16'($urandom); M_StoreData = 16'($urandom); M_ALUout = 16'($urandom);
      mem_ack = (b == 2);
      #1;
      chk("st_wdata", mem_wdata, 16'h1234);
      chk("st_we", 16'(mem_we), 16'h1);
      chk("st_addr", mem_addr, 16'h0040);
      tick();
    end
    chk("st_done_req", 16'(mem_req), 16'h0);
    idle_in();
    tick();
    // ack arriving in the TIMEOUT-th BUSY cycle completes normally
    do_reset();
    M_MemRead = 1; M_ALUout = 16'h0020; mem_rdata = 16'hCAFE;
    tick();
    for (int b = 1; b <= TO; b++) begin
      mem_ack = (b == TO);
      #1;
      chk("late_ack_req", 16'(mem_req), 16'h1);
      tick();
    end
    chk("late_ack_data", M_MemData, 16'hCAFE);
    chk("late_ack_err", 16'(mem_err), 16'h0);
    idle_in();
    tick();
    // no ack: timeout, error pattern and sticky flag
    do_reset();
    M_MemRead = 1; M_ALUout = 16'h0100;
    tick();
    n = 0;
    while (mem_req && n < 50) begin
      n++;
      tick();
    end
    chk("to_busy_cycles", 16'(n), 16'(TO));
    chk("to_data", M_MemData, 16'hFFFF);
    chk("to_err", 16'(mem_err), 16'h1);
    chk("to_done_stall", 16'(mem_stall), 16'h0);
    M_MemRead = 0;
    tick();
    M_MemRead = 1; mem_rdata = 16'h1111;
    tick();
    mem_ack = 1;
    tick();
    chk("to_next_data", M_MemData, 16'h1111);
    chk("to_err_sticky", 16'(mem_err), 16'h1);
    idle_in();
    tick();
    // reset in the middle of BUSY
    do_reset();
    M_MemRead = 1; M_ALUout = 16'h0200;
    tick();
    chk("midrst_busy", 16'(mem_req), 16'h1);
    rst_n = 0;
    #1;
    chk("midrst_req_drop", 16'(mem_req), 16'h0);
    M_MemRead = 0; mem_ack = 1; mem_rdata = 16'h4242;
    rst_n = 1;
    tick();
    chk("midrst_req_after", 16'(mem_req), 16'h0);
    chk("midrst_stall", 16'(mem_stall), 16'h0);
    chk("midrst_data", M_MemData, 16'h0);
    chk("midrst_addr", mem_addr, 16'h0);
    idle_in();
    tick();
    // back-to-back loads, ack in first BUSY cycle
    do_reset();
    M_MemRead = 1; mem_ack = 1; mem_rdata = 16'h1357;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) mem_rdata = 16'h2468;
      #1;
      chk("b2b_stall", 16'(mem_stall), 16'(pat[c]));
      if (c == 2) chk("b2b_data1", M_MemData, 16'h1357);
      if (c == 5) chk("b2b_data2", M_MemData, 16'h2468);
      tick();
    end
    // random traffic against the transaction model
    do_reset();
    m_busy = -1; m_done = 0; m_we = 0; m_err = 0; m_addr = 0; m_wd = 0; m_data = 0;
    for (int c = 0; c < 3000; c++) begin
      M_MemRead = 1'($urandom_range(0, 1)); M_MemWrite = ($urandom_range(0, 2) == 0);
      M_ALUout = 16'($urandom); M_StoreData = 16'($urandom); W_WriteData = 16'($urandom);
      M_SrcReg = 4'($urandom_range(0, 3)); W_Destination = 4'($urandom_range(0, 3));
      W_RegWrite = 1'($urandom_range(0, 1)); mem_rdata = 16'($urandom);
      mem_ack = ($urandom_range(0, 9) < 3);
      #1;
      chk("rnd_req", 16'(mem_req), 16'(m_busy >= 0));
      chk("rnd_stall", 16'(mem_stall), 16'(m_busy >= 0 || (!m_done && (M_MemRead || M_MemWrite))));
      chk("rnd_we", 16'(mem_we), 16'(m_we));
      chk("rnd_addr", mem_addr, m_addr);
      chk("rnd_wdata", mem_wdata, m_wd);
      chk("rnd_data", M_MemData, m_data);
      chk("rnd_err", 16'(mem_err), 16'(m_err));
      model_step();
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
